// File: rtl/car_sim_pkg.sv
// Shared constants for the car simulator keypad path: key index map,
// key count, key-code width and the hold/repeat phase encoding.
package car_sim_pkg;

    localparam int NUM_KEYS   = 12;
    localparam int KEY_CODE_W = 4;

    localparam int KEY_IDX_1     = 0;
    localparam int KEY_IDX_2     = 1;
    localparam int KEY_IDX_3     = 2;
    localparam int KEY_IDX_4     = 3;
    localparam int KEY_IDX_5     = 4;
    localparam int KEY_IDX_6     = 5;
    localparam int KEY_IDX_7     = 6;
    localparam int KEY_IDX_8     = 7;
    localparam int KEY_IDX_9     = 8;
    localparam int KEY_IDX_STAR  = 9;
    localparam int KEY_IDX_0     = 10;
    localparam int KEY_IDX_SHARP = 11;

    typedef enum logic {
        PH_HOLD   = 1'b0,
        PH_REPEAT = 1'b1
    } hold_phase_t;

endpackage

// File: rtl/key_debounce_cell.sv
// One keypad key: two-flop synchronizer, tick-gated counter debouncer,
// press/release edge pulses and the hold/auto-repeat timer.
//
// state     | meaning
// PH_HOLD   | key down (or idle), waiting HOLD_TICKS samples for first repeat
// PH_REPEAT | first repeat done, pulsing every REPEAT_TICKS samples
module key_debounce_cell
    import car_sim_pkg::*;
#(
    parameter int DB_TICKS     = 10,
    parameter int HOLD_TICKS   = 100,
    parameter int REPEAT_TICKS = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_sample,
    input  logic key_raw,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_repeat
);

    localparam logic [3:0] DB_LAST     = 4'(DB_TICKS - 1);
    localparam logic [7:0] HOLD_LAST   = 8'(HOLD_TICKS - 1);
    localparam logic [7:0] REPEAT_LAST = 8'(REPEAT_TICKS - 1);

    logic        sync_meta, key_sync;
    logic [3:0]  db_cnt, db_cnt_next;
    logic [7:0]  hold_cnt, hold_cnt_next;
    hold_phase_t phase, phase_next;
    logic        level_next, press_next, release_next, repeat_next;

    always_comb begin
        level_next    = key_level;
        db_cnt_next   = db_cnt;
        press_next    = 1'b0;
        release_next  = 1'b0;
        repeat_next   = 1'b0;
        hold_cnt_next = hold_cnt;
        phase_next    = phase;

        if (tick_sample) begin
            if (key_sync == key_level) begin
                db_cnt_next = '0;
            end else if (db_cnt == DB_LAST) begin
                level_next   = ~key_level;
                db_cnt_next  = '0;
                press_next   = ~key_level;
                release_next = key_level;
            end else begin
                db_cnt_next = db_cnt + 4'd1;
            end
        end

        // The hold timer only runs while the key stays down; the release
        // sample itself never yields a repeat.
        if (!key_level || release_next) begin
            hold_cnt_next = '0;
            phase_next    = PH_HOLD;
        end else if (tick_sample) begin
            if (phase == PH_HOLD) begin
                if (hold_cnt == HOLD_LAST) begin
                    repeat_next   = 1'b1;
                    hold_cnt_next = '0;
                    phase_next    = PH_REPEAT;
                end else begin
                    hold_cnt_next = hold_cnt + 8'd1;
                end
            end else begin
                if (hold_cnt == REPEAT_LAST) begin
                    repeat_next   = 1'b1;
                    hold_cnt_next = '0;
                end else begin
                    hold_cnt_next = hold_cnt + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_meta   <= 1'b0;
            key_sync    <= 1'b0;
            db_cnt      <= '0;
            hold_cnt    <= '0;
            phase       <= PH_HOLD;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_repeat  <= 1'b0;
        end else begin
            sync_meta   <= key_raw;
            key_sync    <= sync_meta;
            db_cnt      <= db_cnt_next;
            hold_cnt    <= hold_cnt_next;
            phase       <= phase_next;
            key_level   <= level_next;
            key_press   <= press_next;
            key_release <= release_next;
            key_repeat  <= repeat_next;
        end
    end

endmodule

// File: rtl/keypad_conditioner.sv
// Keypad front end: one debounce cell per key plus a lowest-index
// priority encoder that reports each new press as key_code/key_valid.
module keypad_conditioner #(
    parameter int NUM_KEYS     = car_sim_pkg::NUM_KEYS,
    parameter int DB_TICKS     = 10,
    parameter int HOLD_TICKS   = 100,
    parameter int REPEAT_TICKS = 20
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                tick_sample,
    input  logic [NUM_KEYS-1:0]                 key_raw,
    output logic [NUM_KEYS-1:0]                 key_level,
    output logic [NUM_KEYS-1:0]                 key_press,
    output logic [NUM_KEYS-1:0]                 key_release,
    output logic [NUM_KEYS-1:0]                 key_repeat,
    output logic [car_sim_pkg::KEY_CODE_W-1:0]  key_code,
    output logic                                key_valid
);

    localparam int CODE_W = car_sim_pkg::KEY_CODE_W;

    logic [CODE_W-1:0] code_next;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce_cell #(
            .DB_TICKS     (DB_TICKS),
            .HOLD_TICKS   (HOLD_TICKS),
            .REPEAT_TICKS (REPEAT_TICKS)
        ) u_cell (
            .clk         (clk),
            .rst_n       (rst_n),
            .tick_sample (tick_sample),
            .key_raw     (key_raw[k]),
            .key_level   (key_level[k]),
            .key_press   (key_press[k]),
            .key_release (key_release[k]),
            .key_repeat  (key_repeat[k])
        );
    end

    // Scan from the top so the lowest set index wins.
    always_comb begin
        code_next = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (key_press[i]) code_next = CODE_W'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_code  <= '0;
            key_valid <= 1'b0;
        end else begin
            key_valid <= |key_press;
            if (|key_press) key_code <= code_next;
        end
    end

endmodule

// File: tb/tb_keypad_conditioner.sv
// Directed bench for keypad_conditioner: reset, bounce rejection,
// auto-repeat timing, simultaneous presses and mid-operation reset.
module tb_keypad_conditioner;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick_sample = 1'b0;
    logic [11:0] key_raw = '0;
    logic [11:0] key_level, key_press, key_release, key_repeat;
    logic [3:0]  key_code;
    logic        key_valid;

    int n_checks = 0;
    int n_fail   = 0;
    logic [11:0] acc_press, acc_release, acc_repeat;

    keypad_conditioner dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick_sample (tick_sample),
        .key_raw     (key_raw),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_repeat  (key_repeat),
        .key_code    (key_code),
        .key_valid   (key_valid)
    );

    always #5 clk = ~clk;

    task automatic cyc(input logic tk);
        tick_sample = tk;
        @(posedge clk);
        @(negedge clk);
        tick_sample = 1'b0;
        acc_press   |= key_press;
        acc_release |= key_release;
        acc_repeat  |= key_repeat;
    endtask

    // One sample: two idle clocks let the synchronizer settle, then a tick.
    task automatic step();
        cyc(1'b0);
        cyc(1'b0);
        cyc(1'b1);
    endtask

    task automatic clear_acc();
        acc_press = '0;
        acc_release = '0;
        acc_repeat = '0;
    endtask

    task automatic test_reset();
        int found;
        rst_n = 1'b0;
        key_raw = 12'hFFF;
        clear_acc();
        for (int i = 0; i < 3; i++) cyc(1'b1);
        n_checks++;
        if ({key_level, key_press, key_release, key_repeat} !== 48'h0) begin
            n_fail++;
            $display("FAIL reset_vectors: got %h expected 0", {key_level, key_press, key_release, key_repeat});
        end
        n_checks++;
        if ({key_code, key_valid} !== 5'h0) begin
            n_fail++;
            $display("FAIL reset_code_valid: got %h expected 0", {key_code, key_valid});
        end
        rst_n = 1'b1;
        found = -1;
        for (int n = 1; n <= 30; n++) begin
            cyc(1'b1);
            if (key_press != 0) begin
                found = n;
                break;
            end
        end
        n_checks++;
        if (found !== 12) begin
            n_fail++;
            $display("FAIL reset_press_latency: got %0d clk expected 12", found);
        end
        n_checks++;
        if (key_press !== 12'hFFF || key_level !== 12'hFFF) begin
            n_fail++;
            $display("FAIL reset_press_all: press %h level %h expected fff fff", key_press, key_level);
        end
        cyc(1'b1);
        n_checks++;
        if (key_valid !== 1'b1 || key_code !== 4'd0 || key_press !== 12'h0) begin
            n_fail++;
            $display("FAIL reset_encode: valid %b code %0d press %h expected 1 0 000", key_valid, key_code, key_press);
        end
        key_raw = '0;
        found = -1;
        for (int n = 1; n <= 30; n++) begin
            cyc(1'b1);
            if (key_release != 0) begin
                found = n;
                break;
            end
        end
        n_checks++;
        if (found !== 12 || key_release !== 12'hFFF || key_level !== 12'h0) begin
            n_fail++;
            $display("FAIL reset_release: clk %0d release %h level %h expected 12 fff 000", found, key_release, key_level);
        end
        n_checks++;
        if (acc_repeat !== 12'h0 || key_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_repeat: repeat %h valid %b expected 000 0", acc_repeat, key_valid);
        end
        for (int i = 0; i < 3; i++) step();
    endtask

    task automatic test_bounce();
        int found;
        clear_acc();
        for (int s = 0; s < 40; s++) begin
            key_raw[4] = ((s / 3) % 2) == 0;
            step();
        end
        n_checks++;
        if (acc_press !== 12'h0 || acc_release !== 12'h0 || key_level !== 12'h0) begin
            n_fail++;
            $display("FAIL bounce_reject: press %h release %h level %h expected 0", acc_press, acc_release, key_level);
        end
        key_raw[4] = 1'b1;
        found = -1;
        for (int n = 1; n <= 30; n++) begin
            step();
            if (key_press[4]) begin
                found = n;
                break;
            end
        end
        n_checks++;
        if (found !== 10 || key_press !== 12'h010) begin
            n_fail++;
            $display("FAIL bounce_settle: sample %0d press %h expected 10 010", found, key_press);
        end
        cyc(1'b0);
        n_checks++;
        if (key_valid !== 1'b1 || key_code !== 4'd4) begin
            n_fail++;
            $display("FAIL bounce_code: valid %b code %0d expected 1 4", key_valid, key_code);
        end
        key_raw[4] = 1'b0;
        for (int i = 0; i < 12; i++) step();
    endtask

    task automatic test_repeat();
        int press_s, rel_s, rep1, rep2, rep_cnt, press_cnt;
        press_s = -1; rel_s = -1; rep1 = -1; rep2 = -1; rep_cnt = 0; press_cnt = 0;
        clear_acc();
        for (int s = 1; s <= 200; s++) begin
            key_raw[9] = (s <= 139);
            step();
            if (key_press[9]) begin
                press_cnt++;
                press_s = s;
            end
            if (key_release[9]) rel_s = s;
            if (key_repeat[9]) begin
                rep_cnt++;
                if (rep1 < 0) rep1 = s;
                else if (rep2 < 0) rep2 = s;
            end
        end
        n_checks++;
        if (press_s !== 10 || press_cnt !== 1) begin
            n_fail++;
            $display("FAIL repeat_press: sample %0d count %0d expected 10 1", press_s, press_cnt);
        end
        n_checks++;
        if (rep1 !== 110 || rep2 !== 130) begin
            n_fail++;
            $display("FAIL repeat_timing: samples %0d %0d expected 110 130", rep1, rep2);
        end
        n_checks++;
        if (rep_cnt !== 2 || acc_repeat !== 12'h200) begin
            n_fail++;
            $display("FAIL repeat_count: count %0d mask %h expected 2 200", rep_cnt, acc_repeat);
        end
        n_checks++;
        if (rel_s !== 149) begin
            n_fail++;
            $display("FAIL repeat_release: sample %0d expected 149", rel_s);
        end
        n_checks++;
        if (key_code !== 4'd9 || key_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL repeat_code_hold: code %0d valid %b expected 9 0", key_code, key_valid);
        end
    endtask

    task automatic test_simultaneous();
        int found;
        key_raw = 12'hC00;
        found = -1;
        for (int n = 1; n <= 30; n++) begin
            step();
            if (key_press != 0) begin
                found = n;
                break;
            end
        end
        n_checks++;
        if (found !== 10 || key_press !== 12'hC00) begin
            n_fail++;
            $display("FAIL simul_press: sample %0d press %h expected 10 c00", found, key_press);
        end
        cyc(1'b0);
        n_checks++;
        if (key_valid !== 1'b1 || key_code !== 4'd10 || key_press !== 12'h0) begin
            n_fail++;
            $display("FAIL simul_code: valid %b code %0d press %h expected 1 10 000", key_valid, key_code, key_press);
        end
        cyc(1'b0);
        n_checks++;
        if (key_valid !== 1'b0 || key_code !== 4'd10) begin
            n_fail++;
            $display("FAIL simul_hold: valid %b code %0d expected 0 10", key_valid, key_code);
        end
        key_raw = '0;
        for (int i = 0; i < 12; i++) step();
        n_checks++;
        if (key_level !== 12'h0) begin
            n_fail++;
            $display("FAIL simul_release: level %h expected 000", key_level);
        end
    endtask

    task automatic test_reset_mid();
        int found, rep_s;
        key_raw = 12'h080;
        clear_acc();
        for (int i = 0; i < 7; i++) step();
        rst_n = 1'b0;
        cyc(1'b0);
        rst_n = 1'b1;
        n_checks++;
        if ({key_level, key_press, key_repeat, key_code, key_valid} !== 41'h0 || acc_press !== 12'h0) begin
            n_fail++;
            $display("FAIL mid_db_reset: level %h press %h code %0d valid %b expected 0", key_level, acc_press, key_code, key_valid);
        end
        found = -1;
        for (int n = 1; n <= 30; n++) begin
            step();
            if (key_press[7]) begin
                found = n;
                break;
            end
        end
        n_checks++;
        if (found !== 10) begin
            n_fail++;
            $display("FAIL mid_db_fresh: sample %0d expected 10", found);
        end
        for (int i = 0; i < 90; i++) step();
        n_checks++;
        if (acc_repeat !== 12'h0 || key_level !== 12'h080) begin
            n_fail++;
            $display("FAIL mid_hold_pre: repeat %h level %h expected 000 080", acc_repeat, key_level);
        end
        clear_acc();
        rst_n = 1'b0;
        cyc(1'b0);
        rst_n = 1'b1;
        found = -1;
        rep_s = -1;
        for (int s = 1; s <= 150; s++) begin
            step();
            if (key_press[7] && found < 0) found = s;
            if (key_repeat[7] && rep_s < 0) rep_s = s;
        end
        n_checks++;
        if (found !== 10 || rep_s !== 110) begin
            n_fail++;
            $display("FAIL mid_hold_repeat: press %0d repeat %0d expected 10 110", found, rep_s);
        end
        n_checks++;
        if (acc_release !== 12'h0) begin
            n_fail++;
            $display("FAIL mid_no_release: release %h expected 000", acc_release);
        end
        key_raw = '0;
        for (int i = 0; i < 12; i++) step();
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_repeat();
        test_simultaneous();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
